// File: rtl/bsg_mul_comp42_acc.sv
// Pipelined 4:2 carry-save accumulator: beats of four operands are compressed into a
// carry-save accumulator and resolved by one carry-propagate add when a group closes.
module bsg_mul_comp42_acc #(
    parameter int width_p     = 16,
    parameter int acc_width_p = width_p + 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          v_i,
    input  logic [3:0][width_p-1:0]       i,
    input  logic                          last_i,
    output logic                          ready_o,
    output logic                          v_o,
    output logic [acc_width_p-1:0]        data_o,
    input  logic                          yumi_i
);

    typedef logic [acc_width_p-1:0] acc_t;

    typedef struct packed {
        acc_t s;
        acc_t c;
    } cs_t;

    // Two chained 3:2 rows; each carry vector is shifted left with its MSB dropped.
    function automatic cs_t comp42(input acc_t x0, input acc_t x1, input acc_t x2, input acc_t x3);
        acc_t s1;
        acc_t c1;
        cs_t  r;
        s1  = x0 ^ x1 ^ x2;
        c1  = ((x0 & x1) | (x0 & x2) | (x1 & x2)) << 1;
        r.s = s1 ^ c1 ^ x3;
        r.c = ((s1 & c1) | (s1 & x3) | (c1 & x3)) << 1;
        return r;
    endfunction

    acc_t [3:0] op_ext;

    for (genvar gi = 0; gi < 4; gi++) begin : g_ext
        assign op_ext[gi] = acc_t'(i[gi]);
    end

    acc_t a_s_q, a_s_d, a_c_q, a_c_d;
    logic a_v_q, a_v_d, a_last_q, a_last_d;

    acc_t acc_s_q, acc_s_d, acc_c_q, acc_c_d;
    logic first_q, first_d, b_done_q, b_done_d;

    acc_t data_q, data_d;
    logic v_o_q, v_o_d;

    logic c_load, absorb, a_adv, accept;
    cs_t  in_cs, acc_cs;

    always_comb begin
        c_load  = b_done_q & (~v_o_q | yumi_i);
        absorb  = a_v_q & (~b_done_q | c_load);
        a_adv   = ~a_v_q | absorb;
        ready_o = reset_n_i & a_adv;
        accept  = v_i & ready_o;
    end

    always_comb begin
        in_cs  = comp42(op_ext[0], op_ext[1], op_ext[2], op_ext[3]);
        // A fresh group starts from zero instead of the previous, already-resolved sum.
        acc_cs = comp42(first_q ? '0 : acc_s_q, first_q ? '0 : acc_c_q, a_s_q, a_c_q);
    end

    always_comb begin
        a_s_d    = a_s_q;
        a_c_d    = a_c_q;
        a_v_d    = a_v_q;
        a_last_d = a_last_q;
        acc_s_d  = acc_s_q;
        acc_c_d  = acc_c_q;
        first_d  = first_q;
        b_done_d = b_done_q;
        data_d   = data_q;
        v_o_d    = v_o_q;

        if (a_adv) begin
            a_v_d = accept;
            if (accept) begin
                a_s_d    = in_cs.s;
                a_c_d    = in_cs.c;
                a_last_d = last_i;
            end
        end

        if (absorb) begin
            acc_s_d  = acc_cs.s;
            acc_c_d  = acc_cs.c;
            first_d  = a_last_q;
            b_done_d = a_last_q;
        end else if (c_load) begin
            b_done_d = 1'b0;
        end

        if (c_load) begin
            data_d = acc_s_q + acc_c_q;
            v_o_d  = 1'b1;
        end else if (yumi_i) begin
            v_o_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            a_s_q    <= '0;
            a_c_q    <= '0;
            a_v_q    <= 1'b0;
            a_last_q <= 1'b0;
            acc_s_q  <= '0;
            acc_c_q  <= '0;
            first_q  <= 1'b1;
            b_done_q <= 1'b0;
            data_q   <= '0;
            v_o_q    <= 1'b0;
        end else begin
            a_s_q    <= a_s_d;
            a_c_q    <= a_c_d;
            a_v_q    <= a_v_d;
            a_last_q <= a_last_d;
            acc_s_q  <= acc_s_d;
            acc_c_q  <= acc_c_d;
            first_q  <= first_d;
            b_done_q <= b_done_d;
            data_q   <= data_d;
            v_o_q    <= v_o_d;
        end
    end

    assign v_o    = v_o_q;
    assign data_o = data_q;

endmodule

// File: doc/bsg_mul_comp42_acc.md
# bsg_mul_comp42_acc

Pipelined, parametrised 4:2 carry-save accumulator. Each accepted beat supplies four `width_p`-bit operands, which are compressed and folded into a carry-save accumulator of `acc_width_p` bits. On the beat flagged `last_i` the accumulator is resolved by a carry-propagate add and presented on a valid/yumi output. It sits behind partial-product generators in multi-cycle multipliers and dot-product units, replacing one-shot combinational 4:2 compressor rows where operands arrive over several cycles.

## Interface
- `width_p`, default 16: operand width; must be at least 2.
- `acc_width_p`, default `width_p+8`: accumulator and result width; must be at least `width_p`. Operands are zero-extended, and all arithmetic is modulo 2^`acc_width_p`.
- `clk_i`, input, 1: the single clock.
- `reset_n_i`, input, 1: asynchronous, active-low reset.
- `v_i`, input, 1: input beat valid.
- `i`, input, [3:0][width_p-1:0]: four operands for the beat.
- `last_i`, input, 1: this beat closes the current group.
- `ready_o`, output, 1: beat accepted this cycle when `v_i & ready_o`.
- `v_o`, output, 1: result valid.
- `data_o`, output, acc_width_p: group sum modulo 2^`acc_width_p`.
- `yumi_i`, input, 1: consumer takes the result. It is only legal when `v_o` is high.

## Operation
- **Stage A (input register).** On accept, it registers the 4:2 compression of the zero-extended `i[0..3]` as `a_s`/`a_c`, along with `a_last` and `a_v`=1.
  - Carry vectors are shifted left by 1 and the MSB is dropped.
  - The 4:2 carry-in is 0.
- **Stage B (accumulator).** Holds `acc_s`/`acc_c`, a `first` flag (reset value 1), and `b_done`.
  - Stage A's beat is absorbed when `a_v` is set and `b_done` is clear. Absorption is also allowed when `b_done` is set and stage C loads this cycle.
  - On absorb, `acc` ← comp42(`first` ? 0 : `acc_s`, `first` ? 0 : `acc_c`, `a_s`, `a_c`).
  - Also on absorb: `first` ← `a_last`, and `b_done` ← `a_last`.
- **Stage C (output register).** Loads when `b_done` is set and either `v_o` is clear or `yumi_i` is high.
  - On load: `data_o` ← `acc_s`+`acc_c` (full carry-propagate add, mod 2^`acc_width_p`), and `v_o` ← 1.
  - If stage B does not also absorb that cycle, `b_done` ← 0.
- **Output dequeue.** `yumi_i` without a simultaneous load clears `v_o`. `data_o` holds its last value.
- **Stalls and ready.**
  - Stage B stalls only while `b_done` is set and stage C cannot load. `acc`, `b_done` and stage A are then frozen.
  - Stage A advances when `a_v` is clear or its beat is absorbed.
  - `ready_o` = `reset_n_i` & (!`a_v` | A advances).
- **Simultaneous events.**
  - Stage C load, stage B absorbing the first beat of the next group, and a new input accept can all occur in one cycle. Every stage updates from pre-edge values.
  - `yumi_i` together with a load: `v_o` stays 1 and `data_o` takes the new result.
- **Reset (asynchronous, mid-operation included).** Clears `a_v`, `b_done`, `v_o`, `acc_s`, `acc_c` and `data_o` to 0, and sets `first` to 1.
  - Partial groups are discarded.
  - `ready_o` is 0 while `reset_n_i` is low and 1 in the first cycle after release.

## Timing
- Throughput is one beat per cycle, including back-to-back groups and single-beat groups, while the consumer keeps up.
- Latency: if the `last_i` beat is accepted in cycle k, `v_o` rises in cycle k+3 when unstalled (A at k+1, B resolves at k+2, C visible at k+3).
- `data_o` and `v_o` change only on a clock edge or on reset. `ready_o` is combinational in `a_v`, `b_done`, `v_o`, `yumi_i` and `reset_n_i`.
- Maximum occupancy is one result in C, one pending group in B, and one beat in A. The fourth beat waits on `ready_o`.

## Test plan
- **Single-beat group** (`width_p`=16): `i`={1,2,3,4}, `last_i`=1, `yumi_i`=1. Expect `data_o`=10 with `v_o` for exactly one cycle, three cycles after accept.
- **Multi-beat carry save** (`acc_width_p`=24): three beats of all operands 0xFFFF, `last_i` on the third beat. Expect `data_o`=0x0BFFF4.
- **Wrap** (`width_p`=`acc_width_p`=8): two beats of all 0xFF. Expect `data_o`=0xF8 (2040 mod 256).
- **Back-to-back and backpressure.**
  - Alternating single-beat groups {1,1,1,1} and {2,2,2,2} every cycle with `yumi_i`=1. Expect results 4, 8, 4, 8… on consecutive cycles.
  - Then hold `yumi_i`=0. Expect `ready_o` to fall after the third beat is held, and no lost or duplicated results once `yumi_i` returns.
- **Mid-group reset.** Pulse `reset_n_i` low after two beats of a four-beat group. Expect `v_o`=0, `data_o`=0 and `ready_o`=0 during reset. Then a new group of one beat {5,0,0,0} yields exactly 5.
- **Simultaneous yumi and load.** With `v_o`=1 and a resolved group pending, assert `yumi_i`. Expect `v_o` to stay 1 and `data_o` to switch to the new sum on the same edge.
